// File: rtl/voting_pkg.sv
// Shared types for the polling-booth session sequencer:
// FSM state encoding, datapath mode codes and a one-hot check.
package voting_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    CAST,
    LOCKOUT,
    CLOSED,
    CLEARING
  } state_e;

  localparam logic [1:0] DP_MODE_VOTE  = 2'b00;
  localparam logic [1:0] DP_MODE_COUNT = 2'b01;
  localparam logic [1:0] DP_MODE_CLEAR = 2'b10;

  function automatic logic onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/vsc_edge_det.sv
// Rising-edge detector with a registered history bit.
// Ports: clk, rst (async, active high), d_i level in, rise_o edge out.
module vsc_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  // History resets high so a level already asserted
  // at reset release is not mistaken for a new edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b1;
    else     d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/voting_session_ctrl.sv
// Polling-officer session sequencer for the 4-candidate vote counter.
// Ports: officer arm/close/clear and voter sel/confirm in;
//   cast strobe + selection, datapath mode, booth status,
//   invalid/timeout pulses, ballot count and limit flag out.
module voting_session_ctrl
  import voting_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int LOCK_CYCLES    = 16,
  parameter int MAX_BALLOTS    = 255,
  parameter int CLEAR_HOLD     = 8,
  parameter int BW             = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          officer_arm,
  input  logic          officer_close,
  input  logic          officer_clear,
  input  logic [3:0]    voter_sel,
  input  logic          voter_confirm,
  output logic          cast_valid,
  output logic [3:0]    cast_sel,
  output logic [1:0]    dp_mode,
  output logic          booth_ready,
  output logic          invalid_pulse,
  output logic          timeout_pulse,
  output logic          limit_reached,
  output logic [BW-1:0] ballots
);

  localparam int TMAX = (TIMEOUT_CYCLES > LOCK_CYCLES)
                      ? TIMEOUT_CYCLES : LOCK_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam int CW = $clog2(CLEAR_HOLD + 1);

  localparam logic [TW-1:0] T_TO   = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LK   = TW'(LOCK_CYCLES);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [CW-1:0] C_LAST = CW'(CLEAR_HOLD - 1);
  localparam logic [BW-1:0] B_MAX  = BW'(MAX_BALLOTS);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] clr_q, clr_d;
  logic [BW-1:0] ballots_q, ballots_d;
  logic [3:0]    sel_q, sel_d;
  logic [1:0]    dp_q, dp_d;
  logic          inv_q, inv_d;
  logic          to_q, to_d;
  logic          clr_hit;

  logic arm_e, close_e, conf_e;

  vsc_edge_det u_arm (
    .clk    (clk),
    .rst    (rst),
    .d_i    (officer_arm),
    .rise_o (arm_e)
  );

  vsc_edge_det u_close (
    .clk    (clk),
    .rst    (rst),
    .d_i    (officer_close),
    .rise_o (close_e)
  );

  vsc_edge_det u_conf (
    .clk    (clk),
    .rst    (rst),
    .d_i    (voter_confirm),
    .rise_o (conf_e)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    ballots_d = ballots_q;
    sel_d     = sel_q;
    inv_d     = 1'b0;
    to_d      = 1'b0;
    clr_d     = '0;
    clr_hit   = 1'b0;

    // Clear must be held continuously while idle or closed.
    if ((state_q == IDLE || state_q == CLOSED) && officer_clear) begin
      if (clr_q == C_LAST) clr_hit = 1'b1;
      else                 clr_d   = clr_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (clr_hit) begin
          state_d   = CLEARING;
          ballots_d = '0;
          sel_d     = 4'b0000;
        end else if (close_e) begin
          state_d = CLOSED;
        end else if (arm_e && ballots_q != B_MAX) begin
          state_d = ARMED;
          timer_d = T_TO;
        end
      end
      ARMED: begin
        // A valid confirm beats expiry in the same cycle.
        if (conf_e && onehot4(voter_sel)) begin
          state_d   = CAST;
          sel_d     = voter_sel;
          ballots_d = (ballots_q == B_MAX) ? ballots_q
                                           : ballots_q + 1'b1;
        end else begin
          inv_d = conf_e;
          if (timer_q <= T_ONE) begin
            state_d = IDLE;
            timer_d = '0;
            to_d    = 1'b1;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
      end
      CAST: begin
        state_d = LOCKOUT;
        timer_d = T_LK;
      end
      LOCKOUT: begin
        if (timer_q <= T_ONE) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      CLOSED: begin
        if (clr_hit) begin
          state_d   = CLEARING;
          ballots_d = '0;
          sel_d     = 4'b0000;
        end
      end
      CLEARING: state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    dp_d = DP_MODE_VOTE;
    if (state_d == CLOSED)   dp_d = DP_MODE_COUNT;
    if (state_d == CLEARING) dp_d = DP_MODE_CLEAR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      clr_q     <= '0;
      ballots_q <= '0;
      sel_q     <= 4'b0000;
      dp_q      <= DP_MODE_VOTE;
      inv_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      clr_q     <= clr_d;
      ballots_q <= ballots_d;
      sel_q     <= sel_d;
      dp_q      <= dp_d;
      inv_q     <= inv_d;
      to_q      <= to_d;
    end
  end

  assign cast_valid    = (state_q == CAST);
  assign booth_ready   = (state_q == ARMED);
  assign cast_sel      = sel_q;
  assign dp_mode       = dp_q;
  assign invalid_pulse = inv_q;
  assign timeout_pulse = to_q;
  assign ballots       = ballots_q;
  assign limit_reached = (ballots_q == B_MAX);

endmodule

// File: tb/tb_voting_session_ctrl.sv
// Bench for voting_session_ctrl: directed scenarios plus a
// randomized ballot stream checked against a transaction model.
module tb_voting_session_ctrl;

  localparam int TO   = 1000;
  localparam int LK   = 16;
  localparam int MAXB = 2;
  localparam int CH   = 8;

  logic       clk;
  logic       rst;
  logic       officer_arm;
  logic       officer_close;
  logic       officer_clear;
  logic [3:0] voter_sel;
  logic       voter_confirm;
  logic       cast_valid;
  logic [3:0] cast_sel;
  logic [1:0] dp_mode;
  logic       booth_ready;
  logic       invalid_pulse;
  logic       timeout_pulse;
  logic       limit_reached;
  logic [7:0] ballots;

  int vec;
  int errs;
  int exp_ballots;

  voting_session_ctrl #(
    .TIMEOUT_CYCLES (TO),
    .LOCK_CYCLES    (LK),
    .MAX_BALLOTS    (MAXB),
    .CLEAR_HOLD     (CH),
    .BW             (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .officer_arm   (officer_arm),
    .officer_close (officer_close),
    .officer_clear (officer_clear),
    .voter_sel     (voter_sel),
    .voter_confirm (voter_confirm),
    .cast_valid    (cast_valid),
    .cast_sel      (cast_sel),
    .dp_mode       (dp_mode),
    .booth_ready   (booth_ready),
    .invalid_pulse (invalid_pulse),
    .timeout_pulse (timeout_pulse),
    .limit_reached (limit_reached),
    .ballots       (ballots)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    officer_arm = 1'b0;
    officer_close = 1'b0;
    officer_clear = 1'b0;
    voter_sel = 4'b0000;
    voter_confirm = 1'b0;
    repeat (3) tick();
    vec++;
    if ({cast_valid, cast_sel, dp_mode, booth_ready, invalid_pulse,
         timeout_pulse, limit_reached, ballots} !== 19'd0) begin
      errs++;
      $display("FAIL reset_outputs got %b want 0",
        {cast_valid, cast_sel, dp_mode, booth_ready, invalid_pulse,
         timeout_pulse, limit_reached, ballots});
    end
    rst = 1'b0;
    tick();
    vec++;
    if (booth_ready !== 1'b0) begin
      errs++;
      $display("FAIL reset_idle booth_ready got %b want 0", booth_ready);
    end
    exp_ballots = 0;
  endtask

  task automatic test_cast();
    bit bad;
    officer_arm = 1'b1;
    tick();
    officer_arm = 1'b0;
    vec++;
    if (booth_ready !== 1'b1) begin
      errs++;
      $display("FAIL cast_arm booth_ready got %b want 1", booth_ready);
    end
    voter_sel = 4'b0100;
    voter_confirm = 1'b1;
    tick();
    voter_confirm = 1'b0;
    exp_ballots++;
    vec++;
    if ({cast_valid, cast_sel} !== 5'b1_0100) begin
      errs++;
      $display("FAIL cast_strobe got %b want 10100", {cast_valid, cast_sel});
    end
    vec++;
    if (ballots !== 8'(exp_ballots)) begin
      errs++;
      $display("FAIL cast_ballots got %0d want %0d", ballots, exp_ballots);
    end
    tick();
    vec++;
    if (cast_valid !== 1'b0) begin
      errs++;
      $display("FAIL cast_one_cycle got %b want 0", cast_valid);
    end
    bad = 1'b0;
    for (int k = 2; k <= LK; k++) begin
      voter_confirm = (k == 2);
      officer_arm = (k == 5);
      tick();
      if (cast_valid || booth_ready || invalid_pulse) bad = 1'b1;
    end
    voter_confirm = 1'b0;
    officer_arm = 1'b0;
    vec++;
    if ({bad, cast_sel} !== 5'b0_0100) begin
      errs++;
      $display("FAIL lockout_discard got %b want 00100", {bad, cast_sel});
    end
    officer_arm = 1'b1;
    tick();
    officer_arm = 1'b0;
    vec++;
    if (booth_ready !== 1'b0) begin
      errs++;
      $display("FAIL lockout_last_cycle booth_ready got %b want 0",
               booth_ready);
    end
    tick();
    officer_arm = 1'b1;
    tick();
    officer_arm = 1'b0;
    vec++;
    if (booth_ready !== 1'b1) begin
      errs++;
      $display("FAIL post_lockout_arm booth_ready got %b want 1",
               booth_ready);
    end
  endtask

  task automatic test_invalid();
    voter_sel = 4'b0110;
    voter_confirm = 1'b1;
    tick();
    voter_confirm = 1'b0;
    vec++;
    if ({invalid_pulse, booth_ready, cast_valid} !== 3'b110) begin
      errs++;
      $display("FAIL invalid_sel got %b want 110",
               {invalid_pulse, booth_ready, cast_valid});
    end
    tick();
    vec++;
    if ({invalid_pulse, booth_ready} !== 2'b01) begin
      errs++;
      $display("FAIL invalid_one_cycle got %b want 01",
               {invalid_pulse, booth_ready});
    end
    voter_sel = 4'b0001;
    voter_confirm = 1'b1;
    tick();
    voter_confirm = 1'b0;
    exp_ballots++;
    vec++;
    if ({cast_valid, cast_sel, limit_reached} !== 6'b1_0001_1) begin
      errs++;
      $display("FAIL recast got %b want 100011",
               {cast_valid, cast_sel, limit_reached});
    end
    vec++;
    if (ballots !== 8'(exp_ballots)) begin
      errs++;
      $display("FAIL recast_ballots got %0d want %0d", ballots, exp_ballots);
    end
    repeat (LK + 1) tick();
  endtask

  task automatic test_limit();
    officer_arm = 1'b1;
    tick();
    officer_arm = 1'b0;
    vec++;
    if ({booth_ready, limit_reached} !== 2'b01) begin
      errs++;
      $display("FAIL limit_arm got %b want 01", {booth_ready, limit_reached});
    end
    tick();
    voter_sel = 4'b0010;
    voter_confirm = 1'b1;
    tick();
    voter_confirm = 1'b0;
    vec++;
    if ({cast_valid, invalid_pulse, ballots} !== {2'b00, 8'(MAXB)}) begin
      errs++;
      $display("FAIL limit_confirm got %b want %b",
               {cast_valid, invalid_pulse, ballots}, {2'b00, 8'(MAXB)});
    end
  endtask

  task automatic test_clear();
    officer_clear = 1'b1;
    repeat (CH) tick();
    officer_clear = 1'b0;
    exp_ballots = 0;
    vec++;
    if ({dp_mode, ballots, cast_sel} !== 14'b10_00000000_0000) begin
      errs++;
      $display("FAIL clear_idle got %b want 10000000000000",
               {dp_mode, ballots, cast_sel});
    end
    tick();
    vec++;
    if (dp_mode !== 2'b00) begin
      errs++;
      $display("FAIL clear_done dp_mode got %b want 00", dp_mode);
    end
    officer_close = 1'b1;
    officer_arm = 1'b1;
    tick();
    officer_close = 1'b0;
    officer_arm = 1'b0;
    vec++;
    if ({dp_mode, booth_ready} !== 3'b010) begin
      errs++;
      $display("FAIL close_wins got %b want 010", {dp_mode, booth_ready});
    end
    tick();
    officer_arm = 1'b1;
    tick();
    officer_arm = 1'b0;
    vec++;
    if ({dp_mode, booth_ready} !== 3'b010) begin
      errs++;
      $display("FAIL closed_arm got %b want 010", {dp_mode, booth_ready});
    end
    officer_clear = 1'b1;
    repeat (CH - 1) tick();
    officer_clear = 1'b0;
    tick();
    vec++;
    if (dp_mode !== 2'b01) begin
      errs++;
      $display("FAIL clear_short dp_mode got %b want 01", dp_mode);
    end
    officer_clear = 1'b1;
    repeat (CH) tick();
    officer_clear = 1'b0;
    vec++;
    if ({dp_mode, ballots} !== 10'b10_00000000) begin
      errs++;
      $display("FAIL clear_closed got %b want 1000000000", {dp_mode, ballots});
    end
    tick();
    vec++;
    if (dp_mode !== 2'b00) begin
      errs++;
      $display("FAIL clear_closed_done dp_mode got %b want 00", dp_mode);
    end
  endtask

  task automatic test_timeout();
    bit bad;
    officer_arm = 1'b1;
    tick();
    officer_arm = 1'b0;
    bad = 1'b0;
    repeat (TO - 1) begin
      tick();
      if (!booth_ready || timeout_pulse) bad = 1'b1;
    end
    vec++;
    if (bad !== 1'b0) begin
      errs++;
      $display("FAIL timeout_window got %b want 0", bad);
    end
    tick();
    vec++;
    if ({timeout_pulse, booth_ready, ballots} !== {2'b10, 8'(exp_ballots)}) begin
      errs++;
      $display("FAIL timeout_expire got %b want %b",
               {timeout_pulse, booth_ready, ballots}, {2'b10, 8'(exp_ballots)});
    end
    tick();
    vec++;
    if (timeout_pulse !== 1'b0) begin
      errs++;
      $display("FAIL timeout_one_cycle got %b want 0", timeout_pulse);
    end
    officer_arm = 1'b1;
    tick();
    officer_arm = 1'b0;
    repeat (TO - 1) tick();
    voter_sel = 4'b1000;
    voter_confirm = 1'b1;
    tick();
    voter_confirm = 1'b0;
    exp_ballots++;
    vec++;
    if ({cast_valid, timeout_pulse, cast_sel} !== 6'b10_1000) begin
      errs++;
      $display("FAIL expiry_confirm got %b want 101000",
               {cast_valid, timeout_pulse, cast_sel});
    end
    repeat (LK + 1) tick();
  endtask

  task automatic test_random();
    bit armed;
    bit oh;
    int d;
    logic [3:0] s;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        officer_clear = 1'b1;
        repeat (CH) tick();
        officer_clear = 1'b0;
        exp_ballots = 0;
        vec++;
        if ({dp_mode, ballots} !== 10'b10_00000000) begin
          errs++;
          $display("FAIL rnd_clear n=%0d got %b want 1000000000",
                   n, {dp_mode, ballots});
        end
        tick();
        continue;
      end
      officer_arm = 1'b1;
      tick();
      officer_arm = 1'b0;
      armed = (exp_ballots < MAXB);
      vec++;
      if (booth_ready !== armed) begin
        errs++;
        $display("FAIL rnd_arm n=%0d got %b want %b", n, booth_ready, armed);
      end
      d = $urandom_range(0, 30);
      repeat (d) tick();
      oh = $urandom_range(0, 1) == 1;
      if (oh) begin
        s = 4'b0001 << $urandom_range(0, 3);
      end else begin
        do s = 4'($urandom_range(0, 15));
        while ($countones(s) == 1);
      end
      voter_sel = s;
      voter_confirm = 1'b1;
      tick();
      voter_confirm = 1'b0;
      if (armed && oh) exp_ballots++;
      vec++;
      if ({cast_valid, invalid_pulse, ballots} !==
          {armed && oh, armed && !oh, 8'(exp_ballots)}) begin
        errs++;
        $display("FAIL rnd_confirm n=%0d sel=%b got %b want %b", n, s,
                 {cast_valid, invalid_pulse, ballots},
                 {armed && oh, armed && !oh, 8'(exp_ballots)});
      end
      if (armed && oh) begin
        vec++;
        if (cast_sel !== s) begin
          errs++;
          $display("FAIL rnd_sel n=%0d got %b want %b", n, cast_sel, s);
        end
        repeat (LK + 1) tick();
      end else if (armed) begin
        tick();
        s = 4'b0001 << $urandom_range(0, 3);
        voter_sel = s;
        voter_confirm = 1'b1;
        tick();
        voter_confirm = 1'b0;
        exp_ballots++;
        vec++;
        if ({cast_valid, cast_sel} !== {1'b1, s}) begin
          errs++;
          $display("FAIL rnd_retry n=%0d got %b want %b", n,
                   {cast_valid, cast_sel}, {1'b1, s});
        end
        repeat (LK + 1) tick();
      end
      vec++;
      if (limit_reached !== (exp_ballots == MAXB)) begin
        errs++;
        $display("FAIL rnd_limit n=%0d got %b want %b", n, limit_reached,
                 exp_ballots == MAXB);
      end
    end
  endtask

  task automatic test_reset_mid();
    officer_arm = 1'b1;
    tick();
    vec++;
    if (booth_ready !== 1'b1) begin
      errs++;
      $display("FAIL pre_rst_arm got %b want 1", booth_ready);
    end
    #2 rst = 1'b1;
    #1;
    exp_ballots = 0;
    vec++;
    if ({cast_valid, cast_sel, dp_mode, booth_ready, invalid_pulse,
         timeout_pulse, limit_reached, ballots} !== 19'd0) begin
      errs++;
      $display("FAIL rst_armed got %b want 0",
        {cast_valid, cast_sel, dp_mode, booth_ready, invalid_pulse,
         timeout_pulse, limit_reached, ballots});
    end
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    vec++;
    if (booth_ready !== 1'b0) begin
      errs++;
      $display("FAIL arm_held_rst got %b want 0", booth_ready);
    end
    officer_arm = 1'b0;
    tick();
    officer_arm = 1'b1;
    tick();
    officer_arm = 1'b0;
    vec++;
    if (booth_ready !== 1'b1) begin
      errs++;
      $display("FAIL rearm_after_rst got %b want 1", booth_ready);
    end
    voter_sel = 4'b0010;
    voter_confirm = 1'b1;
    tick();
    vec++;
    if (cast_valid !== 1'b1) begin
      errs++;
      $display("FAIL pre_rst_cast got %b want 1", cast_valid);
    end
    #2 rst = 1'b1;
    #1;
    vec++;
    if ({cast_valid, cast_sel, ballots} !== 13'd0) begin
      errs++;
      $display("FAIL rst_mid_cast got %b want 0",
               {cast_valid, cast_sel, ballots});
    end
    voter_confirm = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    vec++;
    if (cast_valid !== 1'b0) begin
      errs++;
      $display("FAIL post_rst_cast got %b want 0", cast_valid);
    end
  endtask

  initial begin
    vec = 0;
    errs = 0;
    exp_ballots = 0;
    test_reset();
    test_cast();
    test_invalid();
    test_limit();
    test_clear();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
